key_pio: RTL

KEY_PIO -- requirements
Module: key_pio

---
 rtl/key_pio_pkg.sv | 21 ++
 rtl/key_debounce.sv | 49 ++++
 rtl/key_pio.sv | 91 +++++++++
 3 files changed

// File: rtl/key_pio_pkg.sv
// ---------------------------------------------------------------------
// key_pio_pkg: register map and shared constants for the key PIO.
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

package key_pio_pkg;

  localparam int ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD    = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

  // Level of an idle (unpressed) active-low key.
  localparam logic KEY_RELEASED = 1'b1;

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------
// key_debounce: two-stage synchroniser plus stable-level debounce for one key.
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module key_debounce
  import key_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic stable
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             synced;
  logic [CNT_W-1:0] count;

  // The counter only runs while the synced level disagrees with the accepted one,
  // so any return to the accepted level restarts the qualification window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= KEY_RELEASED;
      synced <= KEY_RELEASED;
      stable <= KEY_RELEASED;
      count  <= '0;
    end else begin
      meta   <= key_raw;
      synced <= meta;
      if (synced == stable) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        stable <= synced;
        count  <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_pio.sv
// ---------------------------------------------------------------------
// key_pio: debounced key inputs with Avalon-MM registers and edge interrupt.
// Rev 1.0 -- optional macro KEY_PIO_BOTH_EDGES_EN captures release edges too.
// ---------------------------------------------------------------------
`default_nettype none

module key_pio
  import key_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  key_in,
  input  logic [ADDR_W-1:0] s_address,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [31:0]       s_writedata,
  output logic [31:0]       s_readdata,
  output logic              irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign unused_wdata = ^s_writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .key_raw (key_in[i]),
      .stable  (stable[i])
    );
  end

  always_comb begin
`ifdef KEY_PIO_BOTH_EDGES_EN
    edge_hit = stable_d ^ stable;
`else
    edge_hit = stable_d & ~stable;
`endif
    cap_clr = '0;
    if (s_write && (s_address == ADDR_EDGECAP)) begin
      cap_clr = s_writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (s_address)
      ADDR_DATA:    rd_mux = 32'(stable);
      ADDR_IRQMASK: rd_mux = 32'(irqmask);
      ADDR_EDGECAP: rd_mux = 32'(edgecap);
      default:      rd_mux = '0;
    endcase
  end

  // Clear is applied before set so a capture wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d   <= '1;
      edgecap    <= '0;
      irqmask    <= '0;
      s_readdata <= '0;
    end else begin
      stable_d <= stable;
      edgecap  <= (edgecap & ~cap_clr) | edge_hit;
      if (s_write && (s_address == ADDR_IRQMASK)) begin
        irqmask <= s_writedata[WIDTH-1:0];
      end
      if (s_read) begin
        s_readdata <= rd_mux;
      end
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule

`default_nettype wire
